// File: rtl/pcm_sample_fifo.sv
// Capture FIFO for microphone PCM samples: synchronises the receiver's sample-ready level,
// filters by channel, and queues {channel, sample} words behind a 1-cycle registered read port.
module pcm_sample_fifo #(
  parameter int unsigned DW    = 18,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic [DW-1:0]            in_data,
  input  logic                     in_ws,
  input  logic                     in_done,
  input  logic [1:0]               chan_sel,
  input  logic                     clr,
  input  logic                     rd_en,
  output logic [DW-1:0]            rd_data,
  output logic                     rd_chan,
  output logic                     rd_valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic          r_done_s1, r_done_s2, r_done_d;
  logic [2:0]    r_hist_vld;
  logic          r_cap_stb;
  logic [DW-1:0] r_cap_data;
  logic          r_cap_ws;

  logic [DW:0]   r_mem [DEPTH];
  logic [AW:0]   r_wptr, r_rptr;
  logic [DW-1:0] r_rd_data;
  logic          r_rd_chan, r_rd_valid, r_overflow;

  logic          w_edge, w_chan_ok, w_empty, w_full;
  logic          w_wr_req, w_rd, w_wr, w_ovf;
  logic [AW:0]   w_level;

  // r_hist_vld marks which stages hold post-reset samples, so a level already high
  // when reset is released is never mistaken for a rising edge.
  assign w_edge = r_done_s2 & ~r_done_d & r_hist_vld[2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_done_s1  <= 1'b0;
      r_done_s2  <= 1'b0;
      r_done_d   <= 1'b0;
      r_hist_vld <= 3'b000;
      r_cap_stb  <= 1'b0;
      r_cap_data <= '0;
      r_cap_ws   <= 1'b0;
    end else begin
      r_done_s1  <= in_done;
      r_done_s2  <= r_done_s1;
      r_done_d   <= r_done_s2;
      r_hist_vld <= {r_hist_vld[1:0], 1'b1};
      r_cap_stb  <= w_edge;
      if (r_done_s1 && !r_done_s2) begin
        r_cap_data <= in_data;
        r_cap_ws   <= in_ws;
      end
    end
  end

  always_comb begin
    w_chan_ok = 1'b0;
    unique case (chan_sel)
      2'b00: w_chan_ok = ~r_cap_ws;
      2'b01: w_chan_ok = r_cap_ws;
      2'b10: w_chan_ok = 1'b1;
      2'b11: w_chan_ok = 1'b0;
    endcase
  end

  assign w_level  = r_wptr - r_rptr;
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);

  assign w_wr_req = r_cap_stb & enable & ~clr & w_chan_ok;
  assign w_rd     = rd_en & ~w_empty & ~clr;
  // When full, a same-cycle read frees the slot the write lands in.
  assign w_wr     = w_wr_req & (~w_full | w_rd);
  assign w_ovf    = w_wr_req & w_full & ~w_rd;

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr[AW-1:0]] <= {r_cap_ws, r_cap_data};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rd_data  <= '0;
      r_rd_chan  <= 1'b0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_wptr     <= r_wptr + {{AW{1'b0}}, w_wr};
      r_rptr     <= r_rptr + {{AW{1'b0}}, w_rd};
      r_rd_valid <= w_rd;
      r_overflow <= r_overflow | w_ovf;
      if (w_rd) begin
        {r_rd_chan, r_rd_data} <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_chan  = r_rd_chan;
  assign rd_valid = r_rd_valid;
  assign empty    = w_empty;
  assign full     = w_full;
  assign level    = w_level;
  assign overflow = r_overflow;

endmodule
